// File: rtl/conv_encoder.sv
// Rate-1/2 systematic feed-forward convolutional encoder with zero-tail frame termination.
// One info bit in per handshake, one (sys, parity) symbol out per cycle; K-1 tail symbols close each frame.
module conv_encoder #(
    parameter int K = 3,
    parameter logic [K-1:0] GEN = 3'b111
) (
    input  logic clk,
    input  logic rst_n,
    input  logic in_valid,
    output logic in_ready,
    input  logic in_bit,
    input  logic in_last,
    output logic out_valid,
    input  logic out_ready,
    output logic out_sys,
    output logic out_parity,
    output logic out_last
);

    localparam int SW = K - 1;
    localparam int CW = $clog2(K);

    typedef enum logic {DATA, TAIL} state_t;

    state_t          state;
    logic [SW-1:0]   sr;
    logic [CW-1:0]   tail_cnt;
    logic            free;
    logic            accept;

    // Handshake: a transfer happens on a rising edge where valid && ready; the producer
    // holds its fields stable while valid is high and ready is low.
    function automatic logic parity_of(input logic u, input logic [SW-1:0] s);
        logic p;
        p = GEN[0] & u;
        for (int i = 1; i < K; i++) begin
            p = p ^ (GEN[i] & s[i-1]);
        end
        return p;
    endfunction

    function automatic logic [SW-1:0] shift_in(input logic u, input logic [SW-1:0] s);
        logic [SW-1:0] n;
        n    = s << 1;
        n[0] = u;
        return n;
    endfunction

    assign free     = !out_valid || out_ready;
    assign in_ready = (state == DATA) && free;
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= DATA;
            sr         <= '0;
            tail_cnt   <= '0;
            out_valid  <= 1'b0;
            out_sys    <= 1'b0;
            out_parity <= 1'b0;
            out_last   <= 1'b0;
        end else begin
            case (state)
                DATA: begin
                    if (accept) begin
                        out_sys    <= in_bit;
                        out_parity <= parity_of(in_bit, sr);
                        out_last   <= 1'b0;
                        out_valid  <= 1'b1;
                        sr         <= shift_in(in_bit, sr);
                        if (in_last) begin
                            state    <= TAIL;
                            tail_cnt <= '0;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                TAIL: begin
                    // Zero-input symbols flush the register so the trellis ends in state 0.
                    if (free) begin
                        out_sys    <= 1'b0;
                        out_parity <= parity_of(1'b0, sr);
                        out_valid  <= 1'b1;
                        sr         <= shift_in(1'b0, sr);
                        tail_cnt   <= tail_cnt + CW'(1);
                        if (tail_cnt == CW'(K - 2)) begin
                            out_last <= 1'b1;
                            state    <= DATA;
                        end else begin
                            out_last <= 1'b0;
                        end
                    end
                end
                default: state <= DATA;
            endcase
        end
    end

endmodule

// File: doc/conv_encoder.md
# conv_encoder

Rate-1/2 systematic feed-forward convolutional encoder: the transmit-side counterpart of the Viterbi decoder. It accepts one information bit per cycle over a valid/ready handshake and emits one (sys, parity) code symbol per cycle. At the end of each frame it appends K-1 zero tail bits so the trellis terminates in state 0, which the decoder's traceback relies on. The symbol bit order and the parity polynomial are identical to those the decoder's branch-metric units compare against.

## Interface
- K, 3: constraint length; legal range 2..8; shift register holds K-1 past bits.
- GEN, 3'b111: K-bit parity generator. GEN[0] taps the current input bit; GEN[i] taps the input from i cycles earlier.
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit/in_last are valid.
- in_ready  output  1  encoder accepts an input this cycle.
- in_bit  input  1  information bit.
- in_last  input  1  marks the final information bit of the frame.
- out_valid  output  1  out_sys/out_parity/out_last are valid.
- out_ready  input  1  downstream accepts the symbol.
- out_sys  output  1  systematic bit; equals the encoded input bit, 0 for tail symbols.
- out_parity  output  1  parity bit.
- out_last  output  1  marks the final tail symbol of the frame.

## Operation
- State: sr[K-2:0] (sr[0] = most recent past bit), FSM {DATA, TAIL}, and tail_cnt of ceil(log2(K)) bits.
- Parity for input u: GEN[0]&u XOR (XOR over i=1..K-1 of GEN[i]&sr[i-1]).
- Output register slot may load when "free": free = !out_valid || out_ready.
- In DATA, in_ready = free. In TAIL, in_ready = 0.
- Input accept (in_valid && in_ready):
  - out_sys <= in_bit
  - out_parity <= parity(in_bit)
  - out_last <= 0
  - out_valid <= 1
  - sr shifts: sr[0] <= in_bit, sr[i] <= sr[i-1]
  - If in_last: go to TAIL and set tail_cnt <= 0.
- In TAIL, each cycle where free is true:
  - Load a tail symbol with u=0: out_sys <= 0, out_parity <= parity(0), shift 0 into sr.
  - tail_cnt increments.
  - When tail_cnt == K-2 (K-1th tail symbol), set out_last <= 1 and return to DATA.
- If free and nothing loads, out_valid <= 0 when out_ready is high.
- Termination: after the last tail shift, sr == 0. A frame of N info bits always yields exactly N+K-1 symbols.
- No frame-length limit. A frame of one bit (in_last on the first bit) is legal.
- in_last is ignored unless the handshake completes.
- Output fields stay stable while out_valid && !out_ready.

## Timing
- Reset values:
  - out_valid=0, out_sys=0, out_parity=0, out_last=0
  - sr=0, FSM=DATA, tail_cnt=0
  - in_ready follows combinationally, so it is 1 immediately out of reset.
- Latency: the symbol for an input accepted at edge n is valid after edge n, one cycle.
- Throughput: one symbol per cycle with out_ready held high, including across tail symbols and frame boundaries.
- The first bit of the next frame can be accepted in the cycle after the out_last symbol loads, with zero bubbles.
- in_ready depends combinationally on out_ready. There is no combinational path from in_valid to out_*.
- Reset asserted mid-frame or mid-tail: all state clears immediately. The partial frame is discarded and no out_last is emitted.

## Test plan
- Frame: K=3, GEN=111, bits 1,0,1,1, in_last on the 4th, out_ready=1.
  -> Symbols (sys,parity): (1,1),(0,1),(1,0),(1,0),(0,0),(0,1).
  -> out_last only on the 6th symbol; valid on 6 consecutive cycles.
- Single-bit frame: in_bit=1 with in_last.
  -> Symbols (1,1),(0,1),(0,1), out_last on the third.
  -> in_ready=0 for the two tail cycles.
- Backpressure: send the 4-bit frame above with out_ready low for 3 cycles after the first symbol.
  -> in_ready=0 while stalled; symbol (1,1) held stable.
  -> The full sequence is unchanged once out_ready rises.
- Back-to-back frames: frame A = 1 (last), then frame B = 0,1 (last), in_valid held high.
  -> 3 + 4 = 7 contiguous symbols: (1,1),(0,1),(0,1)L,(0,0),(1,1),(0,1),(0,1)L.
  -> Frame B starts from sr=0.
- Reset mid-tail: assert rst_n=0 while the first tail symbol is valid.
  -> All outputs are 0 immediately; after release in_ready=1.
  -> A new frame with bit 1 (last) yields (1,1),(0,1),(0,1).
- Parameter sweep: K=4, GEN=4'b1011, random frames of length 1..64 against a reference model.
  -> Symbol count = N+3; sr=0 after each out_last.
